class_score_collector: RTL and testbench
========================================

// Module: class_score_collector
// PURPOSE
//   Deserialises the classifier head's per-class FP16 score stream (one score per beat, class 0 first)
//   into the N_MATS-wide vector consumed by digit_dec (in_sum/valid_in). Checks frame length against
//   s_last, drops malformed frames, and emits a one-cycle valid with a stable, registered vector.
// PARAMETERS
//   DATA_WIDTH  16  width of one score (FP16 bit pattern, passed through untouched)
//   N_MATS      10  class scores per frame; must be >= 2
//   CNT_W       16  width of the good-frame counter
// PORTS
//   clk          in   1                  clock, all logic on rising edge
//   rst_n        in   1                  reset, synchronous, active-low
//   s_data       in   DATA_WIDTH         score beat
//   s_valid      in   1                  beat present
//   s_last       in   1                  final beat of frame
//   s_ready      out  1                  collector accepts beat
//   out_sum      out  DATA_WIDTH x N_MATS  unpacked array [N_MATS]; element i = i-th beat of last good frame
//   out_valid    out  1                  one-cycle pulse: out_sum holds a new good frame (drives valid_in)
//   frame_err    out  1                  one-cycle pulse: frame dropped (short or long)
//   frame_count  out  CNT_W              good frames emitted since reset, wraps
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=COLLECT, beat count=0, out_sum all '0, out_valid=0, frame_err=0,
//     frame_count=0; s_ready=0 while rst_n=0 (combinational on rst_n), 1 from first cycle after release.
//   Beat accepted iff s_valid && s_ready. s_ready=1 in COLLECT and DRAIN; no backpressure otherwise.
//   State COLLECT (cnt = beats accepted this frame, 0..N_MATS-1):
//     - accept, cnt<N_MATS-1, !s_last: buf[cnt]<=s_data, cnt++.
//     - accept, cnt==N_MATS-1, s_last: good frame. Next edge: out_sum<=buf with element N_MATS-1 =
//       s_data, out_valid=1, frame_count++, cnt=0. Stay COLLECT.
//     - accept, cnt<N_MATS-1, s_last: short frame. Next edge: frame_err=1, cnt=0, out_sum unchanged.
//     - accept, cnt==N_MATS-1, !s_last: long frame. Next edge: frame_err=1, cnt=0, go DRAIN.
//   State DRAIN: accept and discard beats; on accepted s_last -> COLLECT (cnt=0). No further frame_err.
//   Latency: out_valid asserts exactly 1 cycle after the edge accepting the good last beat; out_sum
//     valid in that cycle and held until the next good frame (bad frames never modify out_sum).
//   Back-to-back frames with no idle beat supported at full rate (one beat/cycle, no bubble).
//   out_valid and frame_err are never asserted together; both are 0 in cycles without a triggering event.
//   s_valid low: nothing changes; gaps mid-frame allowed. s_data/s_last ignored when not accepted.
//   frame_count wraps 2^CNT_W-1 -> 0.
//   Reset mid-frame or mid-DRAIN: partial frame discarded, no out_valid/frame_err, out_sum cleared to 0.
//   Internal buf not reset-cleared is acceptable; out_sum must be.
// TESTING
//   1. Reset, then beats 1..10 (s_last on 10th) -> one out_valid pulse, out_sum[i]=i+1, frame_count=1,
//      frame_err=0 throughout.
//   2. Two frames back-to-back (A:0x3C00.., B:0x4000..) no gap -> two out_valid pulses 10 cycles apart,
//      out_sum=A then B, s_ready constant 1.
//   3. Short frame: 7 beats with s_last on 7th, then good frame -> frame_err pulse 1 cycle after beat 7,
//      out_sum unchanged until good frame, then one out_valid; frame_count +1 only.
//   4. Long frame: 13 beats, s_last on 13th, then good frame -> frame_err once after beat 10, beats
//      11-13 discarded, no out_valid, following good frame emitted correctly.
//   5. Random s_valid gaps (~50% duty) inside a good frame -> identical out_sum to gap-free case.
//   6. rst_n low for 1 cycle after beat 5 of a frame, then full good frame -> no pulse from partial,
//      out_sum=0 until new frame completes, frame_count=1.

Source files
------------

// File: rtl/class_score_collector.sv
// Collects one frame of per-class scores into a registered vector.
// Frames whose length does not match s_last are dropped and flagged on frame_err.
module class_score_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int N_MATS     = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] out_sum [N_MATS],
    output logic                  out_valid,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      frame_count
);

    localparam int IDX_W = $clog2(N_MATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MATS - 1);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] beat_buf_q [N_MATS-1];
    logic [DATA_WIDTH-1:0] beat_buf_d [N_MATS-1];
    logic [DATA_WIDTH-1:0] out_sum_q  [N_MATS];
    logic [DATA_WIDTH-1:0] out_sum_d  [N_MATS];
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_W-1:0]      frame_count_q, frame_count_d;
    logic                  accept;
    logic                  at_last_idx;

    // Both states accept unconditionally, so readiness only follows reset.
    assign s_ready     = rst_n;
    assign accept      = s_valid && s_ready;
    assign at_last_idx = (cnt_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beat_buf_d    = beat_buf_q;
        out_sum_d     = out_sum_q;
        out_valid_d   = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        if (accept) begin
            case (state_q)
                COLLECT: begin
                    if (!at_last_idx && !s_last) begin
                        for (int i = 0; i < N_MATS - 1; i++) begin
                            if (cnt_q == IDX_W'(i)) begin
                                beat_buf_d[i] = s_data;
                            end
                        end
                        cnt_d = cnt_q + IDX_W'(1);
                    end else if (at_last_idx && s_last) begin
                        // The final beat bypasses the buffer straight into the output vector.
                        for (int i = 0; i < N_MATS - 1; i++) begin
                            out_sum_d[i] = beat_buf_q[i];
                        end
                        out_sum_d[N_MATS-1] = s_data;
                        out_valid_d   = 1'b1;
                        frame_count_d = frame_count_q + CNT_W'(1);
                        cnt_d         = '0;
                    end else if (!at_last_idx && s_last) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = DRAIN;
                    end
                end
                DRAIN: begin
                    if (s_last) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < N_MATS; i++) begin
                out_sum_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_buf_q    <= beat_buf_d;
            out_sum_q     <= out_sum_d;
            out_valid_q   <= out_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_sum     = out_sum_q;
    assign out_valid   = out_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_class_score_collector.sv
// Scoreboard bench for class_score_collector: good frames push their expected vector,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_class_score_collector;

    localparam int DW = 16;
    localparam int N  = 10;
    localparam int CW = 4;

    typedef logic [N*DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] out_sum [N];
    logic          out_valid;
    logic          frame_err;
    logic [CW-1:0] frame_count;

    vec_t          exp_q[$];
    int            vcyc_q[$];
    vec_t          last_good = '0;
    vec_t          mon_exp;
    logic [CW-1:0] exp_count = '0;
    int            checks = 0;
    int            errors = 0;
    int            valid_pulses = 0;
    int            err_pulses = 0;
    int            ready_drops = 0;
    int            cyc = 0;

    class_score_collector #(
        .DATA_WIDTH(DW),
        .N_MATS    (N),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .out_sum    (out_sum),
        .out_valid  (out_valid),
        .frame_err  (frame_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic vec_t pack_out();
        vec_t v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = out_sum[i];
        return v;
    endfunction

    // Scoreboard side: every out_valid pulse must match the oldest pending good frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!s_ready) ready_drops++;
            if (frame_err) err_pulses++;
            if (out_valid && frame_err) begin
                checks++;
                errors++;
                $display("[TB] FAIL overlap: out_valid=%b frame_err=%b required not both 1", out_valid, frame_err);
            end
            if (out_valid) begin
                valid_pulses++;
                vcyc_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_out_valid: got pulse, scoreboard empty");
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (pack_out() !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL out_sum: got %h required %h", pack_out(), mon_exp);
                    end
                    last_good = mon_exp;
                    exp_count = exp_count + CW'(1);
                    checks++;
                    if (frame_count !== exp_count) begin
                        errors++;
                        $display("[TB] FAIL frame_count_on_pulse: got %0d required %0d", frame_count, exp_count);
                    end
                end
            end
        end
    end

    task automatic idle();
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        s_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic last, input bit gaps);
        int n_gap;
        n_gap = 0;
        while (gaps && n_gap < 4 && $urandom_range(1, 0) == 0) begin
            s_valid = 1'b0;
            s_data  = DW'($urandom);
            s_last  = 1'($urandom);
            @(posedge clk);
            #1;
            n_gap++;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
    endtask

    // Sends n beats base, base+step, ...; s_last on beat n. Checks pulses right after each accepting edge.
    task automatic send_frame(input logic [DW-1:0] base, input logic [DW-1:0] step,
                              input int n, input bit gaps);
        vec_t v;
        logic exp_err;
        logic exp_val;
        v = '0;
        if (n == N) begin
            for (int i = 0; i < N; i++) v[i*DW +: DW] = base + DW'(i) * step;
            exp_q.push_back(v);
        end
        for (int i = 0; i < n; i++) begin
            exp_err = (n < N && i == n - 1) || (n > N && i == N - 1);
            exp_val = (n == N && i == n - 1);
            drive_beat(base + DW'(i) * step, i == n - 1, gaps);
            checks++;
            if (out_valid !== exp_val || frame_err !== exp_err) begin
                errors++;
                $display("[TB] FAIL beat_flags n=%0d beat=%0d: got valid=%b err=%b required valid=%b err=%b",
                         n, i + 1, out_valid, frame_err, exp_val, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (s_ready !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0 ||
            frame_count !== '0 || pack_out() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b valid=%b err=%b count=%0d sum=%h required 0",
                     s_ready, out_valid, frame_err, frame_count, pack_out());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", s_ready);
        end
    endtask

    task automatic test_good_frame();
        int e0;
        e0 = err_pulses;
        send_frame(16'd1, 16'd1, N, 1'b0);
        idle();
        idle();
        checks++;
        if (frame_count !== CW'(1) || valid_pulses !== 1 || err_pulses !== e0) begin
            errors++;
            $display("[TB] FAIL good_frame: count=%0d pulses=%0d errs=%0d required 1 1 %0d",
                     frame_count, valid_pulses, err_pulses, e0);
        end
    endtask

    task automatic test_back_to_back();
        vcyc_q.delete();
        send_frame(16'h3C00, 16'd1, N, 1'b0);
        send_frame(16'h4000, 16'd1, N, 1'b0);
        idle();
        idle();
        checks++;
        if (vcyc_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_pulses: got %0d required 2", vcyc_q.size());
        end else if (vcyc_q[1] - vcyc_q[0] != N) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d required %0d", vcyc_q[1] - vcyc_q[0], N);
        end
        checks++;
        if (ready_drops != 0) begin
            errors++;
            $display("[TB] FAIL b2b_ready: got %0d ready-low cycles required 0", ready_drops);
        end
    endtask

    task automatic test_short_frame();
        int e0;
        int v0;
        e0 = err_pulses;
        v0 = valid_pulses;
        send_frame(16'h1000, 16'd3, 7, 1'b0);
        idle();
        checks++;
        if (err_pulses != e0 + 1 || pack_out() !== last_good) begin
            errors++;
            $display("[TB] FAIL short_frame: errs=%0d sum=%h required %0d %h",
                     err_pulses, pack_out(), e0 + 1, last_good);
        end
        send_frame(16'h1100, 16'd2, N, 1'b0);
        idle();
        checks++;
        if (valid_pulses != v0 + 1 || frame_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL short_recover: pulses=%0d count=%0d required %0d %0d",
                     valid_pulses, frame_count, v0 + 1, exp_count);
        end
    endtask

    task automatic test_long_frame();
        int e0;
        int v0;
        e0 = err_pulses;
        v0 = valid_pulses;
        send_frame(16'h2000, 16'd5, 13, 1'b0);
        idle();
        checks++;
        if (err_pulses != e0 + 1 || valid_pulses != v0 || pack_out() !== last_good) begin
            errors++;
            $display("[TB] FAIL long_frame: errs=%0d pulses=%0d sum=%h required %0d %0d %h",
                     err_pulses, valid_pulses, pack_out(), e0 + 1, v0, last_good);
        end
        send_frame(16'h2100, 16'd1, N, 1'b0);
        idle();
        checks++;
        if (valid_pulses != v0 + 1 || err_pulses != e0 + 1) begin
            errors++;
            $display("[TB] FAIL long_recover: pulses=%0d errs=%0d required %0d %0d",
                     valid_pulses, err_pulses, v0 + 1, e0 + 1);
        end
    endtask

    task automatic test_gaps();
        vec_t ref_v;
        for (int i = 0; i < N; i++) ref_v[i*DW +: DW] = DW'(i + 1);
        send_frame(16'd1, 16'd1, N, 1'b1);
        idle();
        checks++;
        if (pack_out() !== ref_v) begin
            errors++;
            $display("[TB] FAIL gaps_out_sum: got %h required %h", pack_out(), ref_v);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        int e0;
        for (int i = 0; i < 5; i++) drive_beat(16'h0A00 + DW'(i), 1'b0, 1'b0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0 ||
            frame_count !== '0 || pack_out() !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: ready=%b valid=%b err=%b count=%0d sum=%h required 0",
                     s_ready, out_valid, frame_err, frame_count, pack_out());
        end
        rst_n     = 1'b1;
        exp_count = '0;
        last_good = '0;
        exp_q.delete();
        v0 = valid_pulses;
        e0 = err_pulses;
        repeat (3) idle();
        checks++;
        if (pack_out() !== '0 || valid_pulses != v0 || err_pulses != e0) begin
            errors++;
            $display("[TB] FAIL mid_reset_hold: sum=%h pulses=%0d errs=%0d required 0 %0d %0d",
                     pack_out(), valid_pulses, err_pulses, v0, e0);
        end
        send_frame(16'h5000, 16'd7, N, 1'b0);
        idle();
        checks++;
        if (frame_count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL mid_reset_count: got %0d required 1", frame_count);
        end
    endtask

    task automatic test_wrap();
        for (int f = 0; f < (1 << CW); f++) send_frame(16'h6000 + DW'(f << 4), 16'd1, N, 1'b0);
        idle();
        checks++;
        if (frame_count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL count_wrap: got %0d required 1", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_gaps();
        test_reset_mid_frame();
        test_wrap();
        repeat (2) idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d frames pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
